seven_segment_scan_controller: RTL and testbench



---
 rtl/seven_segment_scan_controller_pkg.sv | 29 ++
 rtl/seven_segment_scan_controller_hex_to_segments.sv | 13 +
 rtl/seven_segment_scan_controller.sv | 124 ++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// segment bit positions, scan state type and the hex glyph table.
package seven_segment_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef enum int unsigned {
        SEG_A  = 0,
        SEG_B  = 1,
        SEG_C  = 2,
        SEG_D  = 3,
        SEG_E  = 4,
        SEG_F  = 5,
        SEG_G  = 6,
        SEG_DP = 7
    } segBit_t;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scanState_t;

    // Active-high {g,f,e,d,c,b,a}; b and d use the lowercase glyphs.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_segment_scan_controller_hex_to_segments.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex_to_segments
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Four-digit common-anode display scanner with double-buffered frames and a
// blanking dead-time at the start of every digit slot.
module seven_segment_scan_controller
    import seven_segment_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        cmosClock,
    input  logic        reset,
    input  logic        scanEnable,
    input  logic        loadValid,
    output logic        loadReady,
    input  logic [15:0] loadNibbles,
    input  logic [3:0]  loadDp,
    input  logic [3:0]  loadBlank,
    output logic        frameDone,
    output logic [3:0]  sevenSegmentEnable,
    output logic [7:0]  sevenSegmentData
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_SLOT   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DRIVE_START = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] LAST_DIGIT  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slotCnt;
    logic [CNT_W-1:0] slotCntNext;
    logic [IDX_W-1:0] digitIdx;
    scanState_t       scanState;

    logic [15:0] activeNibbles;
    logic [3:0]  activeDp;
    logic [3:0]  activeBlank;
    logic [15:0] pendingNibbles;
    logic [3:0]  pendingDp;
    logic [3:0]  pendingBlank;
    logic        pendingFull;

    logic        slotWrap;
    logic        loadAccept;
    logic [3:0]  curNibble;
    logic [6:0]  curGlyph;
    logic [3:0]  enableNext;
    logic [7:0]  dataNext;

    always_comb begin
        slotWrap   = scanEnable && (slotCnt == LAST_SLOT);
        frameDone  = slotWrap && (digitIdx == LAST_DIGIT);
        loadReady  = !pendingFull;
        loadAccept = loadValid && !pendingFull;
        if (!scanEnable || slotWrap) begin
            slotCntNext = '0;
        end else begin
            slotCntNext = slotCnt + CNT_W'(1);
        end
    end

    always_comb begin
        curNibble = activeNibbles[{digitIdx, 2'b00} +: 4];
    end

    hex_to_segments u_hexToSegments (
        .nibble (curNibble),
        .glyph  (curGlyph)
    );

    // Gating on scanEnable darkens the pins on the very edge it drops,
    // before the held counter has had a chance to reach BLANK.
    always_comb begin
        enableNext = '1;
        dataNext   = '1;
        if (scanEnable && (scanState == DRIVE)) begin
            enableNext[digitIdx] = 1'b0;
            if (!activeBlank[digitIdx]) begin
                dataNext = ~{activeDp[digitIdx], curGlyph};
            end
        end
    end

    always_ff @(posedge cmosClock) begin
        if (reset) begin
            slotCnt            <= '0;
            digitIdx           <= '0;
            scanState          <= BLANK;
            activeNibbles      <= '0;
            activeDp           <= '0;
            activeBlank        <= '1;
            pendingNibbles     <= '0;
            pendingDp          <= '0;
            pendingBlank       <= '0;
            pendingFull        <= 1'b0;
            sevenSegmentEnable <= '1;
            sevenSegmentData   <= '1;
        end else begin
            slotCnt            <= slotCntNext;
            scanState          <= (slotCntNext < DRIVE_START) ? BLANK : DRIVE;
            sevenSegmentEnable <= enableNext;
            sevenSegmentData   <= dataNext;

            if (!scanEnable) begin
                digitIdx <= '0;
            end else if (slotWrap) begin
                digitIdx <= digitIdx + IDX_W'(1);
            end

            // Pending is never full when a load is accepted, so the two
            // branches cannot both want the buffer in the same cycle.
            if (frameDone && pendingFull) begin
                activeNibbles <= pendingNibbles;
                activeDp      <= pendingDp;
                activeBlank   <= pendingBlank;
                pendingFull   <= 1'b0;
            end else if (loadAccept) begin
                pendingNibbles <= loadNibbles;
                pendingDp      <= loadDp;
                pendingBlank   <= loadBlank;
                pendingFull    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: a frame-level reference model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_seven_segment_scan_controller;

    localparam int unsigned TD    = 8;
    localparam int unsigned BC    = 2;
    localparam int unsigned FRAME = 4 * TD;

    logic        cmosClock = 1'b0;
    logic        reset;
    logic        scanEnable;
    logic        loadValid;
    logic        loadReady;
    logic [15:0] loadNibbles;
    logic [3:0]  loadDp;
    logic [3:0]  loadBlank;
    logic        frameDone;
    logic [3:0]  sevenSegmentEnable;
    logic [7:0]  sevenSegmentData;

    int checks = 0;
    int errors = 0;

    seven_segment_scan_controller #(
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC)
    ) dut (
        .cmosClock          (cmosClock),
        .reset              (reset),
        .scanEnable         (scanEnable),
        .loadValid          (loadValid),
        .loadReady          (loadReady),
        .loadNibbles        (loadNibbles),
        .loadDp             (loadDp),
        .loadBlank          (loadBlank),
        .frameDone          (frameDone),
        .sevenSegmentEnable (sevenSegmentEnable),
        .sevenSegmentData   (sevenSegmentData)
    );

    always #5 cmosClock = ~cmosClock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] refGlyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Reference model: 'phase' is the number of scanning cycles since the
    // scan last (re)started; digit and slot position follow by division.
    typedef struct packed {
        logic [15:0] nib;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } frame_t;

    frame_t activeFrame;
    frame_t pendQ[$];
    int     phase   = 0;
    bit     modelOn = 1'b0;

    always @(posedge cmosClock) begin
        int         d;
        bit         endOfFrame;
        logic [3:0] expEn;
        logic [7:0] expData;
        #1;
        expEn   = 4'hF;
        expData = 8'hFF;
        if (reset === 1'b1) begin
            activeFrame = '{nib: 16'h0, dp: 4'h0, blank: 4'hF};
            pendQ.delete();
            phase   = 0;
            modelOn = 1'b1;
        end else if (modelOn) begin
            if (scanEnable && (phase % TD) >= BC) begin
                d = (phase / TD) % 4;
                expEn[d] = 1'b0;
                if (!activeFrame.blank[d])
                    expData = ~{activeFrame.dp[d], refGlyph(activeFrame.nib[4*d +: 4])};
            end
            endOfFrame = scanEnable && ((phase % FRAME) == FRAME - 1);
            if (endOfFrame && pendQ.size() != 0)
                activeFrame = pendQ.pop_front();
            else if (loadValid && pendQ.size() == 0)
                pendQ.push_back('{nib: loadNibbles, dp: loadDp, blank: loadBlank});
            phase = scanEnable ? phase + 1 : 0;
        end
        if (modelOn) begin
            check("modelEnable", sevenSegmentEnable, expEn);
            check("modelData", sevenSegmentData, expData);
            check("modelFrameDone", frameDone, scanEnable && ((phase % FRAME) == FRAME - 1));
            check("modelLoadReady", loadReady, pendQ.size() == 0);
            check("enableOneHot", $countones(~sevenSegmentEnable) <= 1, 1'b1);
        end
    end

    task automatic waitFrameDone(input string name);
        int n = 0;
        while (frameDone !== 1'b1 && n < 200) begin
            @(negedge cmosClock);
            n++;
        end
        check(name, frameDone, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0] enTab [4];
        logic [7:0] dataTab [4];
        int  n;
        int  lastFd;
        int  frames;
        bit  flag;
        bit  flag2;

        enTab   = '{4'hE, 4'hD, 4'hB, 4'h7};
        dataTab = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

        reset = 1'b1; scanEnable = 1'b0; loadValid = 1'b0;
        loadNibbles = '0; loadDp = '0; loadBlank = '0;
        repeat (3) @(negedge cmosClock);
        check("resetEnable", sevenSegmentEnable, 4'hF);
        check("resetData", sevenSegmentData, 8'hFF);
        check("resetLoadReady", loadReady, 1'b1);
        check("resetFrameDone", frameDone, 1'b0);

        // First frame: load 4321, screen dark until it becomes active.
        reset = 1'b0; scanEnable = 1'b1;
        loadNibbles = 16'h4321; loadDp = 4'h0; loadBlank = 4'h0; loadValid = 1'b1;
        @(negedge cmosClock);
        loadValid = 1'b0;
        check("readyDropsAfterLoad", loadReady, 1'b0);
        n = 0; flag = 1'b1;
        while (frameDone !== 1'b1 && n < 100) begin
            if (sevenSegmentData !== 8'hFF) flag = 1'b0;
            @(negedge cmosClock);
            n++;
        end
        check("firstFrameDoneSeen", frameDone, 1'b1);
        check("firstFrameDoneLatency", n, 30);
        check("darkBeforeFirstFrame", flag, 1'b1);
        @(negedge cmosClock);
        for (int p = 0; p < 32; p++) begin
            @(negedge cmosClock);
            if (p % 8 < 2) check("frame4321Dark", {sevenSegmentEnable, sevenSegmentData}, 12'hFFF);
            else check("frame4321Drive", {sevenSegmentEnable, sevenSegmentData}, {enTab[p / 8], dataTab[p / 8]});
        end

        // Back-to-back loads A then B within one frame.
        loadNibbles = 16'h89AB; loadDp = 4'h0; loadBlank = 4'h0; loadValid = 1'b1;
        @(negedge cmosClock);
        check("readyLowAfterA", loadReady, 1'b0);
        loadNibbles = 16'h5678; loadDp = 4'b0010; loadBlank = 4'h0;
        n = 0; flag = 1'b0;
        while (loadReady !== 1'b1 && n < 100) begin
            if (frameDone === 1'b1) flag = 1'b1;
            @(negedge cmosClock);
            n++;
        end
        check("bStallEnds", loadReady, 1'b1);
        check("bStalledAcrossFrame", flag, 1'b1);
        check("bStallCycles", n, 31);
        @(negedge cmosClock);
        loadValid = 1'b0;
        check("readyLowAfterB", loadReady, 1'b0);
        repeat (2) @(negedge cmosClock);
        check("aShownFirstEnable", sevenSegmentEnable, 4'hE);
        check("aShownFirstData", sevenSegmentData, 8'h83);

        // Decimal points and per-digit blanking.
        n = 0;
        while (loadReady !== 1'b1 && n < 100) begin
            @(negedge cmosClock);
            n++;
        end
        check("readyForFedc", loadReady, 1'b1);
        loadNibbles = 16'hFEDC; loadDp = 4'b0101; loadBlank = 4'b1000; loadValid = 1'b1;
        @(negedge cmosClock);
        loadValid = 1'b0;
        waitFrameDone("fedcFrameDone");
        @(negedge cmosClock);
        for (int p = 0; p < 32; p++) begin
            @(negedge cmosClock);
            if (p == 2)  check("fedcDigit0", {sevenSegmentEnable, sevenSegmentData}, {4'hE, 8'h46});
            if (p == 10) check("fedcDigit1", {sevenSegmentEnable, sevenSegmentData}, {4'hD, 8'hA1});
            if (p == 18) check("fedcDigit2", {sevenSegmentEnable, sevenSegmentData}, {4'hB, 8'h06});
            if (p == 26) check("fedcDigit3Blank", {sevenSegmentEnable, sevenSegmentData}, {4'h7, 8'hFF});
        end

        // Drop scanEnable in the middle of digit 2, load while dark.
        repeat (20) @(negedge cmosClock);
        scanEnable = 1'b0;
        @(negedge cmosClock);
        check("disableDarkNext", sevenSegmentEnable, 4'hF);
        check("disableNoFrameDone", frameDone, 1'b0);
        loadNibbles = 16'h8888; loadDp = 4'hF; loadBlank = 4'h0; loadValid = 1'b1;
        @(negedge cmosClock);
        loadValid = 1'b0;
        check("loadWhileDisabled", loadReady, 1'b0);
        flag = 1'b0; flag2 = 1'b0;
        repeat (40) begin
            @(negedge cmosClock);
            if (frameDone !== 1'b0) flag = 1'b1;
            if (sevenSegmentEnable !== 4'hF) flag2 = 1'b1;
        end
        check("disabledNoFrameDone", flag, 1'b0);
        check("disabledDark", flag2, 1'b0);
        check("disabledNoTransfer", loadReady, 1'b0);
        scanEnable = 1'b1;
        @(negedge cmosClock);
        check("restartDark1", sevenSegmentEnable, 4'hF);
        @(negedge cmosClock);
        check("restartDark2", sevenSegmentEnable, 4'hF);
        @(negedge cmosClock);
        check("restartDigit0", sevenSegmentEnable, 4'hE);

        // One-cycle reset during digit 1 with the 8888 frame still pending.
        n = 0;
        while (sevenSegmentEnable !== 4'hD && n < 40) begin
            @(negedge cmosClock);
            n++;
        end
        check("reachedDigit1", sevenSegmentEnable, 4'hD);
        reset = 1'b1;
        @(negedge cmosClock);
        reset = 1'b0;
        check("midResetEnable", sevenSegmentEnable, 4'hF);
        check("midResetData", sevenSegmentData, 8'hFF);
        check("midResetLoadReady", loadReady, 1'b1);
        flag = 1'b0;
        repeat (3 * FRAME) begin
            @(negedge cmosClock);
            if (sevenSegmentData !== 8'hFF) flag = 1'b1;
        end
        check("pendingNeverShown", flag, 1'b0);

        // 100 continuous frames with random loads; frame period must be 32.
        lastFd = -1; frames = 0; n = 0;
        while (frames < 100 && n < 4000) begin
            loadValid   = ($urandom_range(0, 3) == 0);
            loadNibbles = 16'($urandom);
            loadDp      = 4'($urandom);
            loadBlank   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            @(negedge cmosClock);
            n++;
            if (frameDone === 1'b1) begin
                if (lastFd >= 0) check("framePeriod", n - lastFd, FRAME);
                lastFd = n;
                frames++;
            end
        end
        check("hundredFrames", frames, 100);

        // Random scanEnable drops and occasional resets.
        repeat (1500) begin
            loadValid   = ($urandom_range(0, 2) == 0);
            loadNibbles = 16'($urandom);
            loadDp      = 4'($urandom);
            loadBlank   = 4'($urandom);
            if ($urandom_range(0, 47) == 0) scanEnable = ~scanEnable;
            reset = ($urandom_range(0, 299) == 0);
            @(negedge cmosClock);
        end
        reset = 1'b0; loadValid = 1'b0;
        repeat (2) @(negedge cmosClock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
